// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and constants for the multiply/divide unit
//
// Holds the operation encoding driven by the decoder, the controller state
// encoding, the iteration count and the quotient value returned on a zero
// divisor.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    localparam int          MDU_ITERS     = 32;
    localparam logic [31:0] MDU_DIVZERO_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one combinational iteration of shift-add multiply or restoring divide
//
// Ports:
//   isDiv   in   select divide (1) or multiply (0) iteration
//   acc     in   2*WIDTH working register {upper, lower}
//   b       in   multiplicand / divisor magnitude
//   accNext out  working register after this iteration
//
// Multiply layout: upper = partial product, lower = remaining multiplier bits.
//   Add b to the upper half when the multiplier LSB is set, then shift the
//   whole (carry, upper, lower) chain right by one.
// Divide layout: upper = partial remainder, lower = dividend bits / quotient.
//   Shift left by one, trial-subtract b from the upper half; keep the
//   difference and shift in a 1 when there is no borrow.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 isDiv,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   accNext
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b};
        shifted = acc[2*WIDTH-1:WIDTH-1];
        trial   = shifted - {1'b0, b};
        accNext = acc;
        if (isDiv) begin
            // Partial remainder stays below b, so shifted < 2*b and the top
            // bit of the trial difference is a clean borrow indicator.
            if (!trial[WIDTH]) begin
                accNext = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                accNext = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                accNext = {sum, acc[WIDTH-1:1]};
            end else begin
                accNext = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MIPS multiply/divide unit holding HI/LO
//
// Optional build macro: MDU_DIVZERO_FLAG_EN adds the sticky divZero output.
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   synchronous active-high reset
//   start      in   launch op; only looked at in IDLE
//   op         in   MULT / MULTU / DIV / DIVU (mdu_pkg encoding)
//   operandA   in   rs value
//   operandB   in   rt value
//   writeHi    in   MTHI strobe (IDLE only)
//   writeLo    in   MTLO strobe (IDLE only)
//   writeData  in   MTHI/MTLO data
//   busy       out  high in RUN and FIX
//   done       out  one-cycle pulse when an operation updates HI/LO
//   hi         out  HI register (upper product / remainder)
//   lo         out  LO register (lower product / quotient)
//   divZero    out  (MDU_DIVZERO_FLAG_EN only) last divide had a zero divisor
//
// Operations run on magnitudes for 32 RUN cycles; signs are applied in FIX.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             writeHi,
    input  logic             writeLo,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
`ifdef MDU_DIVZERO_FLAG_EN
    ,
    output logic             divZero
`endif
);

    mdu_state_t state, state_n;

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div_q;
    logic               neg_a;
    logic               neg_b;
    logic               dz;

    logic               accept;
    logic               op_div;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_in_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .isDiv   (is_div_q),
        .acc     (acc),
        .b       (b_mag),
        .accNext (acc_next)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (cnt == CNT_W'(MDU_ITERS - 1)) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == RUN) || (state == FIX);
    end

    // Operand decode and magnitudes at launch
    always_comb begin
        accept    = start && (state == IDLE);
        op_div    = (op == MDU_DIV) || (op == MDU_DIVU);
        op_signed = (op == MDU_MULT) || (op == MDU_DIV);
        a_mag     = (op_signed && operandA[WIDTH-1]) ? -operandA : operandA;
        b_in_mag  = (op_signed && operandB[WIDTH-1]) ? -operandB : operandB;
    end

    // Sign correction applied in FIX
    always_comb begin
        prod = (neg_a ^ neg_b) ? -acc : acc;
        quo  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (!is_div_q) begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else if (dz) begin
            // Zero divisor: the iterations still ran, but the answer is fixed.
            fix_hi = a_raw;
            fix_lo = MDU_DIVZERO_Q;
        end else begin
            fix_hi = rem;
            fix_lo = quo;
        end
    end

    // Datapath and HI/LO
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt      <= '0;
            acc      <= '0;
            b_mag    <= '0;
            a_raw    <= '0;
            is_div_q <= 1'b0;
            neg_a    <= 1'b0;
            neg_b    <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Launch takes priority over a coincident MTHI/MTLO.
                        is_div_q <= op_div;
                        neg_a    <= op_signed && operandA[WIDTH-1];
                        neg_b    <= op_signed && operandB[WIDTH-1];
                        a_raw    <= operandA;
                        b_mag    <= b_in_mag;
                        acc      <= {{WIDTH{1'b0}}, a_mag};
                        cnt      <= '0;
                        dz       <= op_div && (operandB == '0);
                    end else begin
                        if (writeHi) hi <= writeData;
                        if (writeLo) lo <= writeData;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi   <= fix_hi;
                    lo   <= fix_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MDU_DIVZERO_FLAG_EN
    logic dz_flag;

    always_ff @(posedge CLK) begin
        if (RST) begin
            dz_flag <= 1'b0;
        end else if (accept) begin
            dz_flag <= 1'b0;
        end else if ((state == IDLE) && (writeHi || writeLo)) begin
            dz_flag <= 1'b0;
        end else if ((state == FIX) && is_div_q && dz) begin
            dz_flag <= 1'b1;
        end
    end

    assign divZero = dz_flag;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard testbench for mult_div_unit
module tb_mult_div_unit;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        writeHi;
    logic        writeLo;
    logic [31:0] writeData;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_DIVZERO_FLAG_EN
    logic        div_zero;
`endif

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mult_div_unit dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .op        (op),
        .operandA  (operandA),
        .operandB  (operandB),
        .writeHi   (writeHi),
        .writeLo   (writeLo),
        .writeData (writeData),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
`ifdef MDU_DIVZERO_FLAG_EN
        ,
        .divZero   (div_zero)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   ncyc  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever done pulses.
    always @(negedge CLK) begin
        exp_t e;
        ncyc++;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_hi"}, hi, e.exp_hi);
                chk({e.name, "_lo"}, lo, e.exp_lo);
                chk({e.name, "_latency"}, 32'(ncyc), 32'(e.due));
            end
        end else if (sb.size() != 0 && ncyc > sb[0].due) begin
            e = sb.pop_front();
            chk({e.name, "_timeout"}, 32'd0, 32'd1);
        end
    end

    // Caller sits just after a falling edge; start is sampled on the next rising edge.
    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input bit push);
        exp_t e;
        op       = o;
        operandA = a;
        operandB = b;
        start    = 1'b1;
        if (push) begin
            e.exp_hi = eh;
            e.exp_lo = el;
            e.due    = ncyc + 34;
            e.name   = name;
            sb.push_back(e);
        end
        @(negedge CLK); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge CLK); #1;
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
        @(negedge CLK); #1;
    endtask

    initial begin
        int bc;
        RST = 1'b1; start = 1'b0; op = 2'b00; operandA = '0; operandB = '0;
        writeHi = 1'b0; writeLo = 1'b0; writeData = '0;
        repeat (2) @(negedge CLK);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        RST = 1'b0;
        @(negedge CLK); #1;

        // MULT -2 * 3 with busy-window measurement
        issue("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b1) break;
            bc++;
            @(negedge CLK); #1;
        end
        chk("mult_busy_cycles", 32'(bc), 32'd33);
        drain();

        issue("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);
        drain();
        issue("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1);
        drain();
        issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1);
        drain();
        issue("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1);
        drain();
`ifdef MDU_DIVZERO_FLAG_EN
        chk("divzero_set", 32'(div_zero), 32'd1);
`endif
        issue("div_signed_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
        drain();

        // Back-to-back: next start driven in the cycle done is high
        issue("multu_3x5", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1);
        bc = 0;
        while (done !== 1'b1 && bc < 60) begin
            @(negedge CLK); #1;
            bc++;
        end
        chk("b2b_done_seen", 32'(done), 32'd1);
        issue("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1);
`ifdef MDU_DIVZERO_FLAG_EN
        chk("divzero_cleared", 32'(div_zero), 32'd0);
`endif
        drain();

        // Reset in the middle of a MULT
        issue("mult_abort", OP_MULT, 32'd1234, 32'd5678, 32'd0, 32'd0, 0);
        repeat (9) @(negedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK); #1;
        RST = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        issue("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1);
        drain();

        // Start and MTHI while running are ignored
        issue("multu_6x7", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1);
        repeat (4) @(negedge CLK);
        #1;
        start = 1'b1; op = OP_DIVU; operandA = 32'd999; operandB = 32'd3;
        writeHi = 1'b1; writeData = 32'h1234;
        @(negedge CLK); #1;
        start = 1'b0; writeHi = 1'b0;
        drain();
        chk("no_restart_busy", 32'(busy), 32'd0);

        // MTHI in IDLE
        writeHi = 1'b1; writeData = 32'h1234;
        @(negedge CLK); #1;
        writeHi = 1'b0;
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_lo_kept", lo, 32'd42);
        chk("mthi_no_done", 32'(done), 32'd0);

        // MTHI+MTLO together
        writeHi = 1'b1; writeLo = 1'b1; writeData = 32'hABCD;
        @(negedge CLK); #1;
        writeHi = 1'b0; writeLo = 1'b0;
        chk("mthilo_hi", hi, 32'hABCD);
        chk("mthilo_lo", lo, 32'hABCD);

        // Start wins over a coincident MTLO
        writeLo = 1'b1; writeData = 32'd5;
        issue("start_vs_mtlo", OP_MULTU, 32'd2, 32'd2, 32'd0, 32'd4, 1);
        writeLo = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
